// File: rtl/imm_encoder.sv
// imm_encoder: turns a 32-bit value and an ImmSrc class into the immediate field the extender would expand back to it
module imm_encoder #(
  parameter int ROT_STEPS = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  ImmSrc,
  input  logic [31:0] Value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] Instr,
  output logic        Fits
);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  state_t state, state_n;
  logic [31:0] val, val_n;
  logic [3:0] r, r_n;
  logic [23:0] instr_n;
  logic fits_n;
  logic [63:0] dbl;
  logic [31:0] cand;
  logic ldr_fit, br_fit;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign dbl = {val, val} << {r, 1'b0};
  assign cand = dbl[63:32];
  assign ldr_fit = Value[31:12] == 20'd0;
  assign br_fit = Value[1:0] == 2'b00 && (Value[31:25] == 7'h00 || Value[31:25] == 7'h7f);
  // state and result registers; reset discards any in-flight request
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      val <= '0;
      r <= '0;
      Instr <= '0;
      Fits <= 1'b0;
    end else begin
      state <= state_n;
      val <= val_n;
      r <= r_n;
      Instr <= instr_n;
      Fits <= fits_n;
    end
  // next-state: single-cycle classes resolve at accept, class 00 tries one rotation per cycle, smallest first
  always_comb begin
    state_n = state;
    val_n = val;
    r_n = r;
    instr_n = Instr;
    fits_n = Fits;
    case (state)
      IDLE:
        if (in_valid) begin
          val_n = Value;
          r_n = '0;
          state_n = ImmSrc == 2'b00 ? SEARCH : DONE;
          fits_n = ImmSrc == 2'b01 ? ldr_fit : ImmSrc == 2'b10 ? br_fit : 1'b0;
          instr_n = ImmSrc == 2'b01 && ldr_fit ? {12'd0, Value[11:0]} :
                    ImmSrc == 2'b10 && br_fit ? Value[25:2] : 24'd0;
        end
      SEARCH:
        if (cand[31:8] == 24'd0) begin
          state_n = DONE;
          fits_n = 1'b1;
          instr_n = {12'd0, r, cand[7:0]};
        end else if (r == 4'(ROT_STEPS - 1)) begin
          state_n = DONE;
          fits_n = 1'b0;
          instr_n = '0;
        end else r_n = r + 4'd1;
      DONE:
        if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the immediate extension unit: takes a 32-bit value and an ImmSrc class and produces the instruction immediate field that the extender would expand back to that value, plus a Fits flag.
- Used by the on-chip loader/self-test path to build instruction words.
- Valid/ready on input and output.
- The data-processing class runs a multi-cycle rotation search, one candidate per cycle; the other classes complete in one cycle.

Parameters:
- ROT_STEPS, 16, number of rotation candidates searched for ImmSrc=00 (r = 0..ROT_STEPS-1, rotate amount 2r).

Ports:
- clk  input  1  clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- ImmSrc  input  2  class: 00 data-processing, 01 LDR/STR offset, 10 branch offset, 11 undefined.
- Value  input  32  value to encode (byte offset for branch).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- Instr  output  24  encoded field; unused bits 0.
- Fits  output  1  1 = value representable in the class.

Behaviour:
- States: IDLE, SEARCH, DONE.
- in_ready = (state==IDLE).
- out_valid = (state==DONE).
- Accept occurs on an edge with IDLE && in_valid.
  - ImmSrc and Value are latched into internal registers.
  - Inputs are ignored outside IDLE.
- ImmSrc=01, at accept edge go to DONE:
  - Fits = (Value[31:12]==0).
  - Instr = {12'b0, Value[11:0]} if Fits, else 0.
- ImmSrc=10, at accept edge go to DONE:
  - Fits = (Value[1:0]==0) && (Value[31:26] all equal Value[25]).
  - Instr = Value[25:2] if Fits, else 0.
- ImmSrc=11, at accept edge go to DONE with Fits=0, Instr=0.
- ImmSrc=00, at accept edge go to SEARCH with r=0. Each SEARCH edge does the following:
  - Compute cand = Value rotated left by 2r.
  - If cand[31:8]==0, go to DONE with Fits=1 and Instr = {12'b0, r[3:0], cand[7:0]}.
  - Otherwise, if r==ROT_STEPS-1, go to DONE with Fits=0, Instr=0.
  - Otherwise r <= r+1.
- Search order is ascending, so the smallest r wins and the result is unique.
  - Values < 256 always encode with r=0, so they match the current datapath, which zero-extends Instr[7:0] and ignores Instr[11:8].
- Latency, counted as edges from the accept edge (inclusive) to out_valid high:
  - 1 for classes 01/10/11.
  - r_hit+2 for a class-00 hit.
  - ROT_STEPS+1 (17) for a class-00 miss.
- DONE:
  - Instr and Fits are held stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE.
  - No same-cycle re-accept: in_ready is low in DONE, and the earliest next accept is the edge after the handshake.
- reset_n low, at any time, mid-search included:
  - Go to IDLE immediately.
  - r=0, Instr=0, Fits=0, out_valid=0.
  - in_ready=1 once reset_n deasserts; an in-flight request is discarded.
- Value=0 with ImmSrc=00 hits at r=0 with Instr=0, Fits=1.
- The rotate wraps modulo 32.
- r is 4 bits; it never increments past ROT_STEPS-1.

Test Plan:
- Reset, then single-step requests:
  - ImmSrc=00, Value=0x000000FF -> out_valid after 2 edges, Instr=0x0000FF, Fits=1.
  - ImmSrc=00, Value=0xFF000000 -> after 6 edges, Instr=0x0004FF (r=4), Fits=1.
- Class-00 boundaries:
  - ImmSrc=00, Value=0x000003FC -> after 17 edges, Instr=0x000FFF (r=15), Fits=1.
  - Value=0x00000101 -> after 17 edges, Fits=0, Instr=0.
- LDR/STR class: ImmSrc=01.
  - Value=0x00000FFF -> 1 edge, Instr=0x000FFF, Fits=1.
  - Value=0x00001000 -> Fits=0, Instr=0.
- Branch class: ImmSrc=10.
  - 0xFFFFFFF8 -> Instr=0xFFFFFE, Fits=1.
  - 0x01FFFFFC -> Instr=0x7FFFFF, Fits=1.
  - 0x02000000 -> Fits=0.
  - 0x00000006 -> Fits=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after a result -> Instr/Fits stable, in_ready=0, new in_valid ignored.
  - Release -> IDLE the edge after the handshake.
- Reset mid-search: assert reset_n=0 during a class-00 request at r=7 -> out_valid=0, in_ready=1 after release; the next request (01, 0x123) returns Instr=0x000123 in 1 edge.
